// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction fetch controller.
//   state_e    - fetch FSM states (REQ / WAIT / HOLD)
//   PC_STEP    - sequential PC increment
//   DEF_ADDR_MASK - default instruction address space mask
//   NOP_INST   - bubble instruction for the decode side
//   mask_pc()  - applies an address mask to a PC value
package ifetch_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    localparam logic [31:0] PC_STEP       = 32'd4;
    localparam logic [31:0] DEF_ADDR_MASK = 32'h0000_FFFF;
    localparam logic [31:0] NOP_INST      = 32'h0000_0013;

    function automatic logic [31:0] mask_pc(input logic [31:0] pc, input logic [31:0] mask);
        return pc & mask;
    endfunction

endpackage

// File: rtl/ifetch_pc_reg.sv
// ifetch_pc_reg: masked fetch PC register.
//   clk, rst_n : clock, async active-low reset (loads RESET_PC & ADDR_MASK)
//   load       : load load_pc (redirect), takes priority over inc
//   load_pc    : redirect target (masked on load)
//   inc        : advance by PC_STEP with wrap under ADDR_MASK
//   pc         : current fetch PC, always within ADDR_MASK
module ifetch_pc_reg
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] ADDR_MASK = DEF_ADDR_MASK
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_pc,
    input  logic        inc,
    output logic [31:0] pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc <= mask_pc(RESET_PC, ADDR_MASK);
        else if (load)
            pc <= mask_pc(load_pc, ADDR_MASK);
        else if (inc)
            pc <= mask_pc(pc + PC_STEP, ADDR_MASK);
    end

endmodule

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction fetch controller.
//   clk, rst_n      : clock, async active-low reset
//   redirect_valid/pc : taken branch/jalr target, accepted in any state
//   imem_req_*      : single-outstanding fetch request (valid/ready, addr)
//   imem_rsp_*      : fetch response (valid only while a request is outstanding)
//   inst_*          : fetched instruction + PC towards decode (valid/ready)
// Flow is REQ -> WAIT -> HOLD -> REQ. A redirect while a request is in flight
// marks its response to be dropped so stale instructions never reach decode.
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] ADDR_MASK = DEF_ADDR_MASK
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
);

    localparam logic [1:0] ST_REQ  = S_REQ;
    localparam logic [1:0] ST_WAIT = S_WAIT;
    localparam logic [1:0] ST_HOLD = S_HOLD;

    logic [1:0]  state;
    logic        drop;
    logic        run;      // holds off the first request until one clock after reset release
    logic [31:0] fetch_pc;
    logic        req_fire;
    logic        consume;

    assign imem_req_valid = run && (state == ST_REQ);
    assign imem_req_addr  = fetch_pc;
    assign inst_valid     = (state == ST_HOLD);
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign consume        = inst_valid && inst_ready;

    // Redirect always wins over the sequential step, even when decode
    // consumes the held instruction in the same cycle.
    ifetch_pc_reg #(
        .RESET_PC  (RESET_PC),
        .ADDR_MASK (ADDR_MASK)
    ) u_pc (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (redirect_valid),
        .load_pc (redirect_pc),
        .inc     (consume && !redirect_valid),
        .pc      (fetch_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_REQ;
            drop      <= 1'b0;
            run       <= 1'b0;
            inst_data <= 32'h0;
            inst_pc   <= 32'h0;
        end else begin
            run <= 1'b1;
            case (state)
                ST_REQ: begin
                    if (req_fire) begin
                        state <= ST_WAIT;
                        // address just issued is already stale
                        drop  <= redirect_valid;
                    end
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (drop || redirect_valid) begin
                            state <= ST_REQ;
                            drop  <= 1'b0;
                        end else begin
                            inst_data <= imem_rsp_data;
                            inst_pc   <= fetch_pc;
                            state     <= ST_HOLD;
                        end
                    end else if (redirect_valid) begin
                        drop <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (redirect_valid || inst_ready)
                        state <= ST_REQ;
                end
                default: state <= ST_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl: randomized + directed bench for ifetch_ctrl. A memory model
// answers each accepted request after a random delay; the reference tracks the
// architectural "next PC decode should see" and checks every delivered
// instruction against it and against memory contents.
module tb_ifetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] MASK   = 32'h0000_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    ifetch_ctrl #(.RESET_PC(RST_PC), .ADDR_MASK(MASK)) dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // reference model state
    logic [31:0] exp_pc;
    bit          outstanding;
    logic [31:0] out_addr;
    int          rsp_cnt;
    bit          hold_prev;
    logic [31:0] prev_data, prev_pc;
    int          hs_cnt, acc_cnt, cyc, last_hs_cyc, hs_gap;
    bit          hs_now, seen_wrap;
    logic [31:0] last_hs_pc;
    int          dly_lo = 1, dly_hi = 1;

    task automatic model_reset();
        exp_pc      = RST_PC & MASK;
        outstanding = 0;
        hold_prev   = 0;
        last_hs_cyc = -1;
        last_hs_pc  = 32'hFFFF_FFFF;
    endtask

    // One clock: called at a negedge, applies inputs, checks, advances model,
    // returns at the next negedge.
    task automatic cycle(input bit rv, input logic [31:0] rpc, input bit rq, input bit ir);
        bit was_out;
        cyc++;
        hs_now         = 0;
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_req_ready = rq;
        inst_ready     = ir;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        was_out        = outstanding;
        if (outstanding) begin
            if (rsp_cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem(out_addr);
                outstanding    = 0;
            end else rsp_cnt--;
        end
        if (imem_req_valid && rq) begin
            chk("req_overlap", 32'(was_out), 32'd0);
            chk("req_mask", imem_req_addr & ~MASK, 32'd0);
            outstanding = 1;
            out_addr    = imem_req_addr;
            rsp_cnt     = $urandom_range(dly_hi, dly_lo) - 1;
            acc_cnt++;
        end
        if (hold_prev) begin
            chk("hold_valid", 32'(inst_valid), 32'd1);
            chk("hold_data", inst_data, prev_data);
            chk("hold_pc", inst_pc, prev_pc);
        end
        if (inst_valid && ir) begin
            chk("deliv_pc", inst_pc, exp_pc);
            chk("deliv_data", inst_data, mem(inst_pc));
            if (last_hs_pc == 32'h0000_FFFC && inst_pc == 32'h0) seen_wrap = 1;
            hs_gap      = cyc - last_hs_cyc;
            last_hs_cyc = cyc;
            last_hs_pc  = inst_pc;
            hs_now      = 1;
            hs_cnt++;
        end
        hold_prev = inst_valid && !ir && !rv;
        prev_data = inst_data;
        prev_pc   = inst_pc;
        if (rv) exp_pc = rpc & MASK;
        else if (inst_valid && ir) exp_pc = (exp_pc + 32'd4) & MASK;
        @(negedge clk);
    endtask

    task automatic rand_run(input int n, input int p_rd, input int p_rq, input int p_ir);
        logic [31:0] t;
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(2, 0))
                0: t = $urandom;
                1: t = 32'h0000_FFFC | ($urandom & 32'hFFFF_0000);
                default: t = {$urandom_range(65535, 0), 16'h0} | ($urandom_range(15, 0) << 2);
            endcase
            cycle($urandom_range(99, 0) < p_rd, t,
                  $urandom_range(99, 0) < p_rq, $urandom_range(99, 0) < p_ir);
        end
    endtask

    initial begin
        int n, hs0, acc0;
        rst_n = 1'b0;
        redirect_valid = 0; redirect_pc = 0; imem_req_ready = 0;
        imem_rsp_valid = 0; imem_rsp_data = 0; inst_ready = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst_data", inst_data, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        rst_n = 1'b1;
        #1 chk("req_before_clk", 32'(imem_req_valid), 32'd0);
        @(negedge clk);
        chk("req_first", 32'(imem_req_valid), 32'd1);
        chk("req_addr_rst", imem_req_addr, RST_PC & MASK);

        // single-cycle memory, decode always ready: one inst per 3 cycles
        dly_lo = 1; dly_hi = 1;
        for (int i = 0; i < 15; i++) begin
            cycle(0, 0, 1, 1);
            if (hs_now && hs_cnt > 1) chk("latency", 32'(hs_gap), 32'd3);
        end

        // redirect in WAIT, response two cycles after accept is dropped
        dly_lo = 2; dly_hi = 2;
        n = 0;
        while (!imem_req_valid && n < 20) begin cycle(0, 0, 0, 1); n++; end
        chk("to_req_b", 32'(n < 20), 32'd1);
        cycle(0, 0, 1, 1);
        cycle(1, 32'h0001_0040, 1, 1);
        cycle(0, 0, 1, 1);
        chk("drop_no_valid", 32'(inst_valid), 32'd0);
        chk("drop_req_valid", 32'(imem_req_valid), 32'd1);
        chk("drop_req_addr", imem_req_addr, 32'h0000_0040);
        repeat (8) cycle(0, 0, 1, 1);

        // decode stalls in HOLD, then redirect with ready in the same cycle
        dly_lo = 1; dly_hi = 3;
        n = 0;
        while (!inst_valid && n < 20) begin cycle(0, 0, 1, 0); n++; end
        chk("to_hold", 32'(n < 20), 32'd1);
        repeat (5) cycle(0, 0, 1, 0);
        hs0 = hs_cnt;
        cycle(1, 32'h0000_0200, 1, 1);
        chk("hold_consumed_once", 32'(hs_cnt), 32'(hs0 + 1));
        chk("hold_redir_valid", 32'(inst_valid), 32'd0);
        chk("hold_redir_addr", imem_req_addr, 32'h0000_0200);

        // request stalled 4 cycles, redirect in the second one
        cycle(0, 0, 0, 1);
        cycle(1, 32'h0000_0080, 0, 1);
        chk("stall_addr", imem_req_addr, 32'h0000_0080);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        acc0 = acc_cnt;
        cycle(0, 0, 1, 1);
        chk("stall_one_accept", 32'(acc_cnt), 32'(acc0 + 1));
        repeat (8) cycle(0, 0, 1, 1);

        // wrap of the address space
        seen_wrap = 0;
        cycle(1, 32'hABCD_FFFC, 1, 1);
        repeat (20) cycle(0, 0, 1, 1);
        chk("wrap_seen", 32'(seen_wrap), 32'd1);

        // random traffic
        dly_lo = 1; dly_hi = 4;
        rand_run(800, 10, 70, 70);
        rand_run(800, 30, 50, 40);
        rand_run(800, 3, 90, 90);

        // reset while waiting on a response
        dly_lo = 3; dly_hi = 3;
        n = 0;
        while (!(outstanding && !imem_req_valid && !inst_valid) && n < 40) begin
            cycle(0, 0, 1, 1); n++;
        end
        chk("to_wait", 32'(n < 40), 32'd1);
        rst_n = 1'b0;
        imem_rsp_valid = 1'b0;
        #1;
        chk("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("mid_rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("mid_rst_inst_data", inst_data, 32'd0);
        chk("mid_rst_inst_pc", inst_pc, 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("mid_rst_req_pre", 32'(imem_req_valid), 32'd0);
        @(negedge clk);
        chk("mid_rst_req", 32'(imem_req_valid), 32'd1);
        chk("mid_rst_addr", imem_req_addr, RST_PC & MASK);
        dly_lo = 1; dly_hi = 2;
        hs0 = hs_cnt;
        repeat (20) cycle(0, 0, 1, 1);
        chk("post_rst_progress", 32'(hs_cnt > hs0), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
- Consumer of the next-PC value. Owns the architectural PC register and fetches instructions from instruction memory over a valid/ready request/response interface.
- Presents the fetched instruction and its PC to decode over a valid/ready handshake.
- Accepts taken-branch/jalr redirects from the next-PC logic at any time.
- Discards stale in-flight responses after a redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset (masked by ADDR_MASK).
- ADDR_MASK, 32'h0000_FFFF, instruction address space mask; applied to every PC value held or issued.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- redirect_valid  in  1  taken branch/jalr this cycle.
- redirect_pc  in  32  redirect target.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  fetch address.
- imem_rsp_valid  in  1  response valid (1+ cycles after acceptance).
- imem_rsp_data  in  32  instruction word.
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode accepts instruction.
- inst_data  out  32  instruction word.
- inst_pc  out  32  PC of inst_data.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - state=REQ, fetch_pc=RESET_PC&ADDR_MASK, drop=0.
  - imem_req_valid=0, inst_valid=0, inst_data=0, inst_pc=0.
  - imem_req_valid rises on the first clock after deassertion.
- Outstanding requests: at most one outstanding request.
- Responses: imem_rsp_valid is only legal while a request is outstanding. The memory samples the address only on imem_req_valid & imem_req_ready, so the address may change while not accepted.
- Address masking: every PC written into fetch_pc is masked with ADDR_MASK. Sequential increment is (fetch_pc+4)&ADDR_MASK, so it wraps 0xFFFC -> 0x0000.
- States and transitions:
  - REQ: imem_req_valid=1, imem_req_addr=fetch_pc.
    - On req accept, go to WAIT.
  - WAIT: imem_req_valid=0.
    - On rsp_valid with drop=0: inst_data<=rsp_data, inst_pc<=fetch_pc, go to HOLD.
    - On rsp_valid with drop=1: discard the response, drop<=0, go to REQ.
  - HOLD: inst_valid=1; inst_data and inst_pc are stable until accepted.
    - On inst_valid & inst_ready: fetch_pc<=(fetch_pc+4)&ADDR_MASK, go to REQ.
- Redirect (highest priority, any state): fetch_pc <= redirect_pc&ADDR_MASK.
  - REQ, not accepted: stay in REQ; the new address is presented next cycle.
  - REQ, accepted same cycle: go to WAIT with drop=1 (old-address response is discarded).
  - WAIT, no response: drop<=1, stay in WAIT.
  - WAIT, response same cycle: discard it, go to REQ.
  - HOLD: inst_valid drops next cycle, go to REQ. If inst_ready was high that cycle the transfer still counts as consumed, but fetch_pc takes the redirect target, not +4.
- Repeated redirects in WAIT: the last target wins; drop stays 1; exactly one response is discarded.
- Mid-operation reset: returns to reset state immediately. Any in-flight response after reset is a memory-side protocol violation and is not handled.
- Latency: with single-cycle memory (ready=1, rsp next cycle) and inst_ready=1, one instruction is delivered every 3 cycles (REQ, WAIT, HOLD).

Decomposition:
- Shared package ifetch_pkg:
  - State enum {REQ, WAIT, HOLD}.
  - Constants: PC_STEP=4, default ADDR_MASK, NOP_INST=32'h0000_0013 (decode-side bubble).
- One natural sub-module, ifetch_pc_reg: masked PC register with load (redirect) / increment (consume) / hold, async active-low reset. The FSM lives in ifetch_ctrl.

Test Plan:
- Reset release, memory ready=1 with 1-cycle response, inst_ready=1 -> req addrs 0x0,0x4,0x8 one every 3 cycles; inst_pc matches each, inst_data equals memory contents.
- fetch_pc reaches 0xFFFC, consumed -> next imem_req_addr=0x0000 (wrap under ADDR_MASK).
- Redirect to 0x1_0040 during WAIT, response arrives 2 cycles later -> response dropped, inst_valid stays 0, next req addr 0x0040, delivered inst_pc=0x0040.
- In HOLD with inst_ready=0 for 5 cycles -> inst_valid/data/pc stable; then redirect to 0x200 with inst_ready=1 same cycle -> instruction consumed once, next req addr 0x200 (not pc+4).
- imem_req_ready=0 for 4 cycles, redirect to 0x80 in cycle 2 -> imem_req_addr switches to 0x80, accepted once, no duplicate request.
- Assert rst_n low during WAIT -> outputs zero immediately, no response latched; after release, req addr=RESET_PC.
